// File: rtl/alu_driver_if.sv
// alu_driver_if
//   Command and response handshake bundle for alu_driver.
//   master : command source / response consumer (drives cmd_*, rsp_ready)
//   slave  : alu_driver (drives cmd_ready, rsp_valid, rsp_y, rsp_tag, rsp_op)
//   Parameter TAG_W sets the width of the opaque request tag.
//   cmd_op and rsp_op carry the alu_pkg::opcode_e encoding as raw 2-bit
//   values, so this file does not depend on the package.

interface alu_driver_if #(
  parameter int TAG_W = 2
);

  // Command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_y;
  logic [TAG_W-1:0] rsp_tag;
  logic [1:0]       rsp_op;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_a,
    output cmd_b,
    output cmd_tag,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_y,
    input  rsp_tag,
    input  rsp_op,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_a,
    input  cmd_b,
    input  cmd_tag,
    output cmd_ready,
    output rsp_valid,
    output rsp_y,
    output rsp_tag,
    output rsp_op,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_driver.sv
// alu_driver
//   Command-side initiator for an external combinational 4-bit alu.
//   A command accepted on the cmd channel is held in holding registers that
//   drive the alu continuously; the alu result is registered one cycle later
//   and returned, tagged, on the rsp channel. Completed response handshakes
//   are counted in done_cnt (wraps at 256).
//
//   Ports:
//     clk      in   single clock, rising edge
//     rst      in   asynchronous active-high reset
//     bus      slave modport of alu_driver_if (cmd_* / rsp_* handshakes)
//     alu_a    out  operand A to alu
//     alu_b    out  operand B to alu
//     alu_op   out  opcode to alu (alu_pkg::opcode_e encoding)
//     alu_y    in   alu result, combinational from alu_a/alu_b/alu_op
//     done_cnt out  number of completed response handshakes
//     err      out  sticky result-mismatch flag
//
//   Configuration macro: ALU_DRV_CHECK_EN
//     defined   : a reference model checks alu_y at the capture edge and
//                 sets err on mismatch (sticky until rst)
//     undefined : no checker is built and err is tied to 0

package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_XOR = 2'd3
  } opcode_e;

endpackage

module alu_driver
  import alu_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  alu_driver_if.slave  bus,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [1:0]   alu_op,
  input  logic [3:0]   alu_y,
  output logic [7:0]   done_cnt,
  output logic         err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e           state;
  state_e           state_next;

  opcode_e          hold_op;
  logic [3:0]       hold_a;
  logic [3:0]       hold_b;
  logic [TAG_W-1:0] hold_tag;

  logic [3:0]       rsp_y_q;
  logic [TAG_W-1:0] rsp_tag_q;
  opcode_e          rsp_op_q;
  logic [7:0]       done_cnt_q;

  logic             cmd_fire;
  logic             rsp_fire;
  logic             capture;

  // Handshake qualifiers; cmd_ready and rsp_valid are pure decodes of the
  // registered state, so neither depends combinationally on the other side.
  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign rsp_fire = bus.rsp_valid && bus.rsp_ready;
  assign capture  = (state == ST_ISSUE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      ST_IDLE:  bus.cmd_ready = 1'b1;
      ST_RESP:  bus.rsp_valid = 1'b1;
      default: begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
      end
    endcase
  end

  // Holding registers only load on an accepted command, so the alu inputs
  // stay stable for the whole command and remain valid afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_op  <= OP_ADD;
      hold_a   <= '0;
      hold_b   <= '0;
      hold_tag <= '0;
    end else if (cmd_fire) begin
      hold_op  <= opcode_e'(bus.cmd_op);
      hold_a   <= bus.cmd_a;
      hold_b   <= bus.cmd_b;
      hold_tag <= bus.cmd_tag;
    end
  end

  // Response payload is captured at the end of ISSUE and then held
  // untouched through any amount of backpressure in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_y_q   <= '0;
      rsp_tag_q <= '0;
      rsp_op_q  <= OP_ADD;
    end else if (capture) begin
      rsp_y_q   <= alu_y;
      rsp_tag_q <= hold_tag;
      rsp_op_q  <= hold_op;
    end
  end

  // Completion counter, wraps naturally from 255 to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_q <= '0;
    end else if (rsp_fire) begin
      done_cnt_q <= done_cnt_q + 8'd1;
    end
  end

  assign alu_a       = hold_a;
  assign alu_b       = hold_b;
  assign alu_op      = hold_op;

  assign bus.rsp_y   = rsp_y_q;
  assign bus.rsp_tag = rsp_tag_q;
  assign bus.rsp_op  = rsp_op_q;
  assign done_cnt    = done_cnt_q;

`ifdef ALU_DRV_CHECK_EN

  logic [3:0] ref_y;
  logic       err_q;

  // Independent reference of the alu, computed from the holding registers
  // so it sees exactly the operands the alu is being driven with.
  always_comb begin
    ref_y = '0;
    case (hold_op)
      OP_ADD:  ref_y = hold_a + hold_b;
      OP_SUB:  ref_y = hold_a - hold_b;
      OP_MUL:  ref_y = hold_a * hold_b;
      OP_XOR:  ref_y = hold_a ^ hold_b;
      default: ref_y = '0;
    endcase
  end

  // Sticky mismatch flag; the response still carries the real alu_y
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (capture && (alu_y != ref_y)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

`else

  assign err = 1'b0;

`endif

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver
//   Self-checking bench for alu_driver. Provides a behavioural alu on the
//   alu_* ports (with an override that forces the result to zero), runs a
//   table of directed commands back-to-back, then hand-written sequences for
//   backpressure, reset in RESP, the checker flag and counter wrap.

module tb_alu_driver;
  import alu_pkg::*;

  localparam int TAG_W = 2;

  typedef struct {
    opcode_e    op;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] tag;
    logic [3:0] exp_y;
    string      name;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_y;
  logic [7:0] done_cnt;
  logic       err;
  logic       force_zero;

  int         tests_run;
  int         tests_failed;
  int         exp_done;
  logic       exp_err_flag;

  vec_t       vectors[8];

  alu_driver_if #(.TAG_W(TAG_W)) bus ();

  alu_driver #(.TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_y    (alu_y),
    .done_cnt (done_cnt),
    .err      (err)
  );

  // Behavioural stand-in for the external alu
  always_comb begin
    alu_y = 4'h0;
    case (alu_op)
      2'd0: alu_y = alu_a + alu_b;
      2'd1: alu_y = alu_a - alu_b;
      2'd2: alu_y = alu_a * alu_b;
      2'd3: alu_y = alu_a ^ alu_b;
      default: alu_y = 4'h0;
    endcase
    if (force_zero) begin
      alu_y = 4'h0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One full command with rsp_ready held high; checks latency, alu drive,
  // payload, cmd_ready timing and the counter.
  task automatic applyStimulus(input opcode_e op, input logic [3:0] a,
                               input logic [3:0] b, input logic [1:0] tag,
                               input logic [3:0] exp_y, input string name);
    bus.rsp_ready = 1'b1;
    checkOutput({name, " cmd_ready idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_tag   = tag;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = ~a;
    bus.cmd_b     = ~b;
    bus.cmd_tag   = ~tag;
    bus.cmd_op    = ~op;
    checkOutput({name, " issue cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    checkOutput({name, " issue rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({name, " alu_a"}, 32'(alu_a), 32'(a));
    checkOutput({name, " alu_b"}, 32'(alu_b), 32'(b));
    checkOutput({name, " alu_op"}, 32'(alu_op), 32'(op));
    @(posedge clk); #1;
    checkOutput({name, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    checkOutput({name, " rsp_y"}, 32'(bus.rsp_y), 32'(exp_y));
    checkOutput({name, " rsp_tag"}, 32'(bus.rsp_tag), 32'(tag));
    checkOutput({name, " rsp_op"}, 32'(bus.rsp_op), 32'(op));
    checkOutput({name, " resp cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    exp_done = (exp_done + 1) % 256;
    checkOutput({name, " post rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({name, " post cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    checkOutput({name, " done_cnt"}, 32'(done_cnt), 32'(exp_done));
  endtask

  // Unchecked command used to advance the counter quickly
  task automatic quickCommand(input logic [3:0] a);
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = a;
    bus.cmd_b     = 4'h1;
    bus.cmd_tag   = 2'd0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Reset asserted away from a clock edge, outputs checked before any edge
  task automatic pulseReset(input string name);
    #2;
    rst = 1'b1;
    #1;
    checkOutput({name, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({name, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    checkOutput({name, " done_cnt"}, 32'(done_cnt), 32'd0);
    exp_done = 0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    exp_done      = 0;
    force_zero    = 1'b0;
`ifdef ALU_DRV_CHECK_EN
    exp_err_flag  = 1'b1;
`else
    exp_err_flag  = 1'b0;
`endif
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_a     = 4'h0;
    bus.cmd_b     = 4'h0;
    bus.cmd_tag   = 2'd0;
    bus.rsp_ready = 1'b0;

    vectors[0] = '{OP_ADD, 4'h7, 4'hA, 2'd1, 4'h1, "add_7_a"};
    vectors[1] = '{OP_SUB, 4'h3, 4'h5, 2'd2, 4'hE, "sub_3_5"};
    vectors[2] = '{OP_MUL, 4'h6, 4'h3, 2'd3, 4'h2, "mul_6_3"};
    vectors[3] = '{OP_XOR, 4'hC, 4'h5, 2'd0, 4'h9, "xor_c_5"};
    vectors[4] = '{OP_ADD, 4'hF, 4'h1, 2'd1, 4'h0, "add_wrap"};
    vectors[5] = '{OP_MUL, 4'hF, 4'hF, 2'd2, 4'h1, "mul_f_f"};
    vectors[6] = '{OP_SUB, 4'h0, 4'h1, 2'd3, 4'hF, "sub_wrap"};
    vectors[7] = '{OP_XOR, 4'hA, 4'hA, 2'd0, 4'h0, "xor_self"};

    // Reset state
    #1;
    checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset rsp_y", 32'(bus.rsp_y), 32'd0);
    checkOutput("reset rsp_tag", 32'(bus.rsp_tag), 32'd0);
    checkOutput("reset rsp_op", 32'(bus.rsp_op), 32'd0);
    checkOutput("reset alu_a", 32'(alu_a), 32'd0);
    checkOutput("reset alu_b", 32'(alu_b), 32'd0);
    checkOutput("reset alu_op", 32'(alu_op), 32'd0);
    checkOutput("reset done_cnt", 32'(done_cnt), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    #11;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, back-to-back
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vectors[i].op, vectors[i].a, vectors[i].b,
                    vectors[i].tag, vectors[i].exp_y, vectors[i].name);
    end

    // Backpressure: XOR C^5 held for 5 cycles with rsp_ready low
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_XOR;
    bus.cmd_a     = 4'hC;
    bus.cmd_b     = 4'h5;
    bus.cmd_tag   = 2'd2;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp rsp_valid c%0d", c), 32'(bus.rsp_valid), 32'd1);
      checkOutput($sformatf("bp rsp_y c%0d", c), 32'(bus.rsp_y), 32'h9);
      checkOutput($sformatf("bp rsp_tag c%0d", c), 32'(bus.rsp_tag), 32'd2);
      checkOutput($sformatf("bp cmd_ready c%0d", c), 32'(bus.cmd_ready), 32'd0);
      checkOutput($sformatf("bp done_cnt c%0d", c), 32'(done_cnt), 32'(exp_done));
      @(posedge clk); #1;
    end
    checkOutput("bp still valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_done++;
    checkOutput("bp post rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("bp post cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("bp done_cnt", 32'(done_cnt), 32'(exp_done));

    // Reset while in RESP
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = 4'h4;
    bus.cmd_b     = 4'h4;
    bus.cmd_tag   = 2'd1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_resp pre rsp_valid", 32'(bus.rsp_valid), 32'd1);
    pulseReset("rst_resp");
    checkOutput("rst_resp after rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_resp after done_cnt", 32'(done_cnt), 32'd0);

    // Checker: corrupted result, then a correct command
    force_zero = 1'b1;
    applyStimulus(OP_ADD, 4'h2, 4'h2, 2'd1, 4'h0, "chk_bad");
    force_zero = 1'b0;
    checkOutput("chk err set", 32'(err), 32'(exp_err_flag));
    applyStimulus(OP_ADD, 4'h1, 4'h1, 2'd2, 4'h2, "chk_good");
    checkOutput("chk err sticky", 32'(err), 32'(exp_err_flag));
    pulseReset("chk_rst");
    checkOutput("chk err cleared", 32'(err), 32'd0);

    // Counter wrap after 256 completions from reset
    for (int n = 0; n < 255; n++) begin
      quickCommand(4'(n));
    end
    checkOutput("wrap done_cnt 255", 32'(done_cnt), 32'd255);
    quickCommand(4'h3);
    checkOutput("wrap done_cnt 0", 32'(done_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
# alu_driver

Command-side initiator for the 4-bit `alu` datapath: accepts operation requests on a valid/ready command port and presents operands and opcode to an external `alu` instance. It samples the ALU result and returns it, tagged, on a valid/ready response port. It sits between a command source (testbench, microsequencer) and the combinational `alu`, adding flow control, result registration and a completion counter.

## Interface

- `TAG_W`, default 2: width of the request tag returned with each result.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  driver can accept a command.
- `cmd_op`  in  2  `alu_pkg::opcode_e` encoding: ADD=0, SUB=1, MUL=2, XOR=3.
- `cmd_a`, `cmd_b`  in  4 each  operands.
- `cmd_tag`  in  TAG_W  opaque request tag.
- `alu_a`, `alu_b`  out  4 each  operands to `alu`.
- `alu_op`  out  2  opcode to `alu`.
- `alu_y`  in  4  result from `alu`, combinational from `alu_a`/`alu_b`/`alu_op`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_y`  out  4  registered ALU result.
- `rsp_tag`  out  TAG_W  tag of the completed command.
- `rsp_op`  out  2  opcode of the completed command.
- `done_cnt`  out  8  count of completed response handshakes.
- `err`  out  1  sticky result-mismatch flag (see Configuration).

## Operation

- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, latch op, a, b and tag into holding registers, then go to ISSUE.
- ISSUE:
  - `cmd_ready`=0.
  - `alu_a`/`alu_b`/`alu_op` are driven from the holding registers at all times, not only in ISSUE.
  - At the end of the ISSUE cycle, register `alu_y` into `rsp_y`, then go to RESP.
- RESP:
  - `rsp_valid`=1. `rsp_y`/`rsp_tag`/`rsp_op` are held stable.
  - On `rsp_valid && rsp_ready`, increment `done_cnt` and go to IDLE.
- `cmd_ready` is a registered state decode only and does not depend on `rsp_ready`. Commands are never accepted outside IDLE.
- Arithmetic is performed by `alu` and is modulo 16: ADD and SUB wrap; MUL keeps the low 4 bits of the product. The driver does not modify results.
- `done_cnt` wraps from 255 to 0.
- Reset values: state=IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_y`=0, `rsp_tag`=0, `rsp_op`=0, holding registers=0 (so `alu_a`=`alu_b`=0 and `alu_op`=ADD), `done_cnt`=0, `err`=0.
- Reset mid-operation (ISSUE or RESP) aborts the command: no response is produced and `done_cnt` is not incremented.

## Timing

- Command accepted at edge N → ISSUE during cycle N..N+1 → `rsp_valid` high after edge N+1.
- Accept-to-response latency is 2 edges minimum.
- Best-case throughput is one command per 3 cycles (IDLE, ISSUE, RESP), assuming `rsp_ready`=1.
- Backpressure: `rsp_valid` and payload are held indefinitely while `rsp_ready`=0.
- `cmd_ready` returns to 1 one edge after the response handshake.
- `rst` assertion clears all state immediately, without waiting for a clock. Deassertion takes effect at the next rising edge.

## Configuration

- `ALU_DRV_CHECK_EN` defined:
  - An internal reference model computes the expected 4-bit result from the holding registers.
  - When `alu_y` differs at the ISSUE capture edge, `err` is set. It stays 1 until `rst`.
  - The response is still delivered normally, carrying the actual `alu_y`.
- `ALU_DRV_CHECK_EN` undefined: no checker logic is built and `err` is tied to 0.

## Test plan

- ADD: a=4'h7, b=4'hA, tag=1, `rsp_ready`=1 → `rsp_valid` 2 edges after accept with `rsp_y`=4'h1, `rsp_tag`=1, `rsp_op`=ADD; `done_cnt`=1.
- SUB then MUL back-to-back: SUB 3−5, then MUL 6×3 → `rsp_y`=4'hE, then 4'h2. The second `cmd_ready` is not asserted until the cycle after the first response handshake.
- Backpressure: XOR a=4'hC, b=4'h5, `rsp_ready`=0 for 5 cycles → `rsp_valid`=1 with `rsp_y`=4'h9 stable throughout, `cmd_ready`=0 throughout; handshake on the 6th cycle, then IDLE.
- Reset mid-RESP: assert `rst` while `rsp_valid`=1 → `rsp_valid`=0 and `cmd_ready`=1 immediately after reset, without waiting for a clock; `done_cnt`=0.
- Counter wrap: 256 consecutive completed commands → `done_cnt` reads 0.
- With `ALU_DRV_CHECK_EN`: force `alu_y`=4'h0 for ADD 2+2 → `rsp_y`=4'h0 and `err`=1, still 1 after the next correct command; without the macro, `err`=0.
